idct2_1d_serial: RTL and testbench
==================================

IDCT2_1D_SERIAL -- requirements
Module: idct2_1d_serial

Interface
- REQ-001: The module SHALL have parameter SHIFT, default 7, giving the rounding right-shift applied to each accumulated output.
- REQ-002: The module SHALL have parameter OUT_W, default 16, giving the output sample width.
- REQ-003: The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004: The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-005: The module SHALL have port in_valid, input, 1 bit: a coefficient block is presented.
- REQ-006: The module SHALL have port in_ready, output, 1 bit: the block accepts a new coefficient block.
- REQ-007: The module SHALL have port in_n, input, 2 bits: transform size; 00=4, 01=8, 10=16, 11=32.
- REQ-008: The module SHALL have port in_coef, input, [0:511]: 32 signed 16-bit coefficients; coefficient j occupies bits [16j:16j+15], with bit 16j as MSB.
- REQ-009: The module SHALL have port out_valid, output, 1 bit: out_data holds a valid sample.
- REQ-010: The module SHALL have port out_ready, input, 1 bit: the sink accepts the sample.
- REQ-011: The module SHALL have port out_data, output, OUT_W bits: signed reconstructed sample y[i].
- REQ-012: The module SHALL have port out_idx, output, 5 bits: sample index i.
- REQ-013: The module SHALL have port out_last, output, 1 bit: high with the sample where i = N-1.

Function
- REQ-014: The block SHALL compute the inverse DCT-II y[i] = sum over k=0..N-1 of c[k]*T_N[k][i], using only coefficients 0..N-1.
- REQ-015: T_N[k][i] SHALL be derived from m = ((2i+1)*k*(32/N)) mod 128; if m > 64, then m = 128-m; if m = 32, the value is 0; if m > 32, the value is -g[64-m]; otherwise it is g[m].
- REQ-016: The table g SHALL be g[0]=64, g[16]=64, g[8]=83, g[24]=36, g[4]=89, g[12]=75, g[20]=50, g[28]=18, g[2]=90, g[6]=87, g[10]=80, g[14]=70, g[18]=57, g[22]=43, g[26]=25, g[30]=9, and for odd m = 1,3,...,31 the values 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4.
- REQ-017: The FSM SHALL have three states, IDLE, MAC and OUT, and in_ready SHALL be high exactly when the state is IDLE.
- REQ-018: On a clock edge with in_valid=1 and in_ready=1, the block SHALL latch in_coef and in_n, set i=0, clear the accumulator and go to MAC; changes on in_n or in_coef after capture SHALL have no effect.
- REQ-019: MAC SHALL perform one 16x8 signed multiply-accumulate per cycle for k=0..N-1 into a 32-bit signed accumulator, then go to OUT after N cycles.
- REQ-020: On entering OUT, out_data SHALL equal sat((acc + 2^(SHIFT-1)) >>> SHIFT), where >>> is an arithmetic shift and sat clips to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- REQ-021: On entering OUT, out_idx SHALL equal i, out_last SHALL equal (i == N-1), and out_valid SHALL be 1.
- REQ-022: The first out_valid SHALL rise exactly N cycles after the capture edge.
- REQ-023: In OUT, out_valid, out_data, out_idx and out_last SHALL hold stable until the edge with out_ready=1.
- REQ-024: On the transfer edge in OUT, if i < N-1 the block SHALL increment i, clear the accumulator, drop out_valid and go to MAC; if i = N-1 it SHALL drop out_valid and go to IDLE.
- REQ-025: Without stalls, block throughput SHALL be N*(N+1) cycles.
- REQ-026: in_valid SHALL be ignored outside IDLE, and no input buffering SHALL exist.
- REQ-027: out_ready SHALL be ignored when out_valid=0.
- REQ-028: Coefficient values SHALL be full-range signed 16-bit, and -32768 SHALL be handled without overflow in the accumulator.

Reset
- REQ-029: While rst_n=0, the block SHALL be in state IDLE with in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, and the accumulator and i cleared.
- REQ-030: Reset asserted at any point SHALL abort the current block immediately, and no partial samples SHALL be emitted after release.
- REQ-031: The first capture SHALL be possible on the first rising edge after rst_n deasserts.

Verification
- REQ-032: The bench SHALL cover: N=4, c=[64,0,0,0], out_ready=1 -> samples 32,32,32,32; first out_valid 4 cycles after capture; out_last only with idx 3.
- REQ-033: The bench SHALL cover: N=8, c[1]=128, others 0 -> 89,75,50,18,-18,-50,-75,-89 at idx 0..7.
- REQ-034: The bench SHALL cover: N=32, all c=32767 -> y[0]=32767 (saturated); block completes in 32*33 cycles; in_ready returns to 1 after the last transfer.
- REQ-035: The bench SHALL cover: N=4 DC case with out_ready held low 5 cycles on idx 1 -> out_data=32 and idx=1 held stable; no sample lost or duplicated; in_ready stays 0.
- REQ-036: The bench SHALL cover: rst_n pulsed low mid-MAC of an N=16 block -> out_valid=0 during reset; in_ready=1 after release; a following N=4 DC block yields 32,32,32,32.
- REQ-037: The bench SHALL cover: in_valid held high with a different in_n and in_coef during OUT -> ignored; the current block output is unchanged.

Source files
------------

// File: rtl/idct2_1d_serial.sv
// Serial 1-D inverse DCT-II for N = 4/8/16/32 using the HEVC-style integer basis.
// Each output sample needs N multiply-accumulate cycles, then one handshake cycle in OUT.
module idct2_1d_serial #(
   parameter int SHIFT = 7,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_n,
   input  logic [0:511]     in_coef,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [4:0]       out_idx,
   output logic             out_last
);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   localparam logic signed [32:0] RND     = 33'sd1 <<< (SHIFT - 1);
   localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
   localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_W - 1));

   // Basis magnitudes for folded angle indices 0..31 (index 32 is the zero crossing).
   function automatic logic signed [7:0] g_val(input logic [5:0] m);
      logic signed [7:0] v;
      case (m)
         6'd0:  v = 8'sd64;  6'd1:  v = 8'sd90;  6'd2:  v = 8'sd90;  6'd3:  v = 8'sd90;
         6'd4:  v = 8'sd89;  6'd5:  v = 8'sd88;  6'd6:  v = 8'sd87;  6'd7:  v = 8'sd85;
         6'd8:  v = 8'sd83;  6'd9:  v = 8'sd82;  6'd10: v = 8'sd80;  6'd11: v = 8'sd78;
         6'd12: v = 8'sd75;  6'd13: v = 8'sd73;  6'd14: v = 8'sd70;  6'd15: v = 8'sd67;
         6'd16: v = 8'sd64;  6'd17: v = 8'sd61;  6'd18: v = 8'sd57;  6'd19: v = 8'sd54;
         6'd20: v = 8'sd50;  6'd21: v = 8'sd46;  6'd22: v = 8'sd43;  6'd23: v = 8'sd38;
         6'd24: v = 8'sd36;  6'd25: v = 8'sd31;  6'd26: v = 8'sd25;  6'd27: v = 8'sd22;
         6'd28: v = 8'sd18;  6'd29: v = 8'sd13;  6'd30: v = 8'sd9;   6'd31: v = 8'sd4;
         default: v = 8'sd0;
      endcase
      return v;
   endfunction

   // Angle index is (2i+1)*k scaled to a 128-step circle; mod 128 is just the low 7 bits.
   function automatic logic signed [7:0] t_val(input logic [1:0] n, input logic [4:0] i,
                                               input logic [4:0] k);
      logic [11:0] p;
      logic [11:0] sh;
      logic [6:0]  m;
      logic signed [7:0] v;
      p  = 12'({i, 1'b1}) * 12'(k);
      sh = p << (2'd3 - n);
      m  = sh[6:0];
      if (m > 7'd64)
         m = 7'd0 - m;
      if (m == 7'd32)
         v = 8'sd0;
      else if (m > 7'd32)
         v = -g_val(6'(7'd64 - m));
      else
         v = g_val(m[5:0]);
      return v;
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          n_q, n_d;
   logic [0:511]        coef_q, coef_d;
   logic [4:0]          i_q, i_d;
   logic [4:0]          k_q, k_d;
   logic signed [31:0]  acc_q, acc_d;
   logic [OUT_W-1:0]    out_data_q, out_data_d;
   logic [4:0]          out_idx_q, out_idx_d;
   logic                out_last_q, out_last_d;

   logic [4:0]          nm1;
   logic signed [15:0]  coef_k;
   logic signed [7:0]   t_k;
   logic signed [23:0]  prod_w;
   logic signed [31:0]  acc_sum;
   logic signed [32:0]  rnd;
   logic signed [32:0]  shifted;
   logic [OUT_W-1:0]    sat_val;

   always_comb begin
      nm1     = 5'((6'd4 << n_q) - 6'd1);
      coef_k  = coef_q[{k_q, 4'b0000} +: 16];
      t_k     = t_val(n_q, i_q, k_q);
      prod_w  = 24'(coef_k) * 24'(t_k);
      acc_sum = acc_q + 32'(prod_w);
      rnd     = 33'(acc_sum) + RND;
      shifted = rnd >>> SHIFT;
      if (shifted > SAT_MAX)
         sat_val = SAT_MAX[OUT_W-1:0];
      else if (shifted < SAT_MIN)
         sat_val = SAT_MIN[OUT_W-1:0];
      else
         sat_val = shifted[OUT_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      coef_d     = coef_q;
      i_d        = i_q;
      k_d        = k_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      out_last_d = out_last_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               coef_d  = in_coef;
               n_d     = in_n;
               i_d     = '0;
               k_d     = '0;
               acc_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            if (k_q == nm1) begin
               out_data_d = sat_val;
               out_idx_d  = i_q;
               out_last_d = (i_q == nm1);
               state_d    = OUT;
            end else begin
               k_d = k_q + 5'd1;
            end
         end
         OUT: begin
            if (out_ready) begin
               if (i_q == nm1) begin
                  state_d = IDLE;
               end else begin
                  i_d     = i_q + 5'd1;
                  k_d     = '0;
                  acc_d   = '0;
                  state_d = MAC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         coef_q     <= '0;
         i_q        <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
         out_idx_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         coef_q     <= coef_d;
         i_q        <= i_d;
         k_q        <= k_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
         out_idx_q  <= out_idx_d;
         out_last_q <= out_last_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_idct2_1d_serial.sv
// Self-checking bench for idct2_1d_serial: directed and random blocks compared against
// a direct evaluation of the inverse DCT formula.
module tb_idct2_1d_serial;

   localparam int SHIFT = 7;
   localparam int OUT_W = 16;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [1:0]     in_n;
   logic [0:511]   in_coef;
   logic           out_valid;
   logic           out_ready;
   logic [15:0]    out_data;
   logic [4:0]     out_idx;
   logic           out_last;

   int n_checks = 0;
   int n_fails  = 0;
   int blk_coef[32];

   idct2_1d_serial #(.SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_coef(in_coef),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int g_tab(input int m);
      int odd_vals[16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
      if (m % 2 == 1) return odd_vals[(m - 1) / 2];
      case (m)
         0, 16: return 64;
         8:  return 83;  24: return 36;
         4:  return 89;  12: return 75;  20: return 50;  28: return 18;
         2:  return 90;  6:  return 87;  10: return 80;  14: return 70;
         18: return 57;  22: return 43;  26: return 25;  30: return 9;
         default: return 0;
      endcase
   endfunction

   function automatic int basis(input int nn, input int k, input int i);
      int m;
      m = ((2 * i + 1) * k * (32 / nn)) % 128;
      if (m > 64) m = 128 - m;
      if (m == 32) return 0;
      if (m > 32) return -g_tab(64 - m);
      return g_tab(m);
   endfunction

   function automatic int ref_sample(input int nn, input int i);
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < nn; k++) acc += longint'(blk_coef[k]) * basis(nn, k, i);
      r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   function automatic logic [0:511] pack_coef();
      logic [0:511] p;
      for (int j = 0; j < 32; j++) p[16*j +: 16] = 16'(blk_coef[j]);
      return p;
   endfunction

   task automatic clear_coef();
      for (int j = 0; j < 32; j++) blk_coef[j] = 0;
   endtask

   task automatic random_coef();
      for (int j = 0; j < 32; j++) begin
         blk_coef[j] = int'($urandom_range(0, 65535)) - 32768;
         if ($urandom_range(0, 9) == 0) blk_coef[j] = -32768;
      end
   endtask

   // Present a block and return right after the capture edge (caller is after a negedge).
   task automatic capture(input int n_code);
      int guard;
      guard = 0;
      while (!in_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL capture_wait: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_n     = 2'(n_code);
      in_coef  = pack_coef();
      @(posedge clk);
      #1;
   endtask

   task automatic run_block(input string name, input int n_code, input int stall_idx,
                            input int stall_len, input bit hold_junk);
      int nn, cyc, got, first_lat, stall_left, budget, done_cyc;
      int exp_y[32];
      bit fin;
      nn = 4 << n_code;
      for (int i = 0; i < nn; i++) exp_y[i] = ref_sample(nn, i);
      capture(n_code);
      if (hold_junk) begin
         in_n    = 2'(n_code + 1);
         in_coef = {16{32'hA5A5_5A5A}};
      end else begin
         in_valid = 1'b0;
      end
      cyc = 0; got = 0; first_lat = -1; stall_left = stall_len; fin = 0; done_cyc = -1;
      budget = nn * (nn + 1) + stall_len + 20;
      while (!fin && cyc < budget) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (out_valid) begin
            if (first_lat < 0) first_lat = cyc;
            n_checks += 4;
            if (out_idx !== 5'(got)) begin
               n_fails++;
               $display("[TB] FAIL %s idx: got %0d required %0d", name, out_idx, got);
            end
            if (out_data !== 16'(exp_y[got])) begin
               n_fails++;
               $display("[TB] FAIL %s data[%0d]: got %0d required %0d", name, got,
                        $signed(out_data), exp_y[got]);
            end
            if (out_last !== (got == nn - 1)) begin
               n_fails++;
               $display("[TB] FAIL %s last[%0d]: got %b required %b", name, got, out_last,
                        (got == nn - 1));
            end
            if (in_ready !== 1'b0) begin
               n_fails++;
               $display("[TB] FAIL %s in_ready_busy: got %b required 0", name, in_ready);
            end
            if (got == stall_idx && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = 1'b1;
               if (got == nn - 1) begin
                  in_valid = 1'b0;
                  fin      = 1'b1;
                  done_cyc = cyc + 1;
               end
               got++;
            end
         end
      end
      n_checks++;
      if (!fin) begin
         n_fails++;
         $display("[TB] FAIL %s timeout: got %0d samples required %0d", name, got, nn);
         in_valid  = 1'b0;
         out_ready = 1'b1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      n_checks += 4;
      if (first_lat !== nn) begin
         n_fails++;
         $display("[TB] FAIL %s latency: got %0d required %0d", name, first_lat, nn);
      end
      if (done_cyc !== nn * (nn + 1) + stall_len) begin
         n_fails++;
         $display("[TB] FAIL %s block_cycles: got %0d required %0d", name, done_cyc,
                  nn * (nn + 1) + stall_len);
      end
      if (in_ready !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL %s in_ready_end: got %b required 1", name, in_ready);
      end
      if (out_valid !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL %s out_valid_end: got %b required 0", name, out_valid);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks += 5;
      if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset in_ready: got %b required 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset out_valid: got %b required 0", out_valid); end
      if (out_data !== 16'd0) begin n_fails++; $display("[TB] FAIL reset out_data: got %0d required 0", out_data); end
      if (out_idx !== 5'd0) begin n_fails++; $display("[TB] FAIL reset out_idx: got %0d required 0", out_idx); end
      if (out_last !== 1'b0) begin n_fails++; $display("[TB] FAIL reset out_last: got %b required 0", out_last); end
      rst_n = 1'b1;
   endtask

   task automatic test_dc4();
      clear_coef();
      blk_coef[0] = 64;
      run_block("dc4", 0, -1, 0, 1'b0);
   endtask

   task automatic test_odd8();
      clear_coef();
      blk_coef[1] = 128;
      run_block("odd8", 1, -1, 0, 1'b0);
   endtask

   task automatic test_sat32();
      for (int j = 0; j < 32; j++) blk_coef[j] = 32767;
      run_block("sat32", 3, -1, 0, 1'b0);
   endtask

   task automatic test_stall();
      clear_coef();
      blk_coef[0] = 64;
      run_block("stall4", 0, 1, 5, 1'b0);
   endtask

   task automatic test_abort();
      random_coef();
      capture(2);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL abort in_ready_mac: got %b required 0", in_ready); end
      rst_n = 1'b0;
      #1;
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL abort out_valid_rst: got %b required 0", out_valid); end
      if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL abort in_ready_rst: got %b required 1", in_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL abort in_ready_rel: got %b required 1", in_ready); end
      clear_coef();
      blk_coef[0] = 64;
      run_block("after_abort", 0, -1, 0, 1'b0);
   endtask

   task automatic test_ignore_input();
      random_coef();
      run_block("ignore8", 1, 3, 2, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < 6; b++) begin
         int nc;
         nc = (b == 5) ? 3 : int'($urandom_range(0, 2));
         random_coef();
         run_block($sformatf("rand%0d", b), nc, int'($urandom_range(0, (4 << nc) - 1)),
                   int'($urandom_range(0, 3)), 1'(b % 2));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_n      = 2'd0;
      in_coef   = '0;
      out_ready = 1'b1;
      test_reset();
      test_dc4();
      test_odd8();
      test_sat32();
      test_stall();
      test_abort();
      test_ignore_input();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
